jk_ff_bank: RTL and testbench

JK_FF_BANK -- requirements
Module: jk_ff_bank

---
 rtl/jk_pkg.sv | 12 +
 rtl/jk_ff_cell.sv | 71 +++++++
 rtl/jk_ff_bank.sv | 60 ++++++
 tb/tb_jk_ff_bank.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - shared mode encodings for the JK flip-flop bank
package jk_pkg;

   // Per-bit function selected by the 2-bit mode input
   typedef enum logic [1:0] {
      MODE_JK = 2'b00,
      MODE_SR = 2'b01,
      MODE_T  = 2'b10,
      MODE_D  = 2'b11
   } mode_t;

endpackage

// File: rtl/jk_ff_cell.sv
// rtl/jk_ff_cell.sv - one falling-edge JK/SR/T/D flip-flop bit with change and illegal flags
module jk_ff_cell
   import jk_pkg::*;
#(
   parameter logic RST_BIT = 1'b0
) (
   input  logic  i_clk,
   input  logic  i_rst,
   input  logic  i_en,
   input  mode_t i_mode,
   input  logic  i_a,
   input  logic  i_b,
   output logic  o_q,
   output logic  o_qbar,
   output logic  o_changed,
   output logic  o_illegal
);

   logic r_q;
   logic r_qbar;
   logic r_changed;
   logic w_next;

   // Next-state selection; every unlisted combination holds the current value
   always_comb begin
      w_next = r_q;
      case (i_mode)
         MODE_JK: begin
            case ({i_a, i_b})
               2'b01:   w_next = 1'b0;
               2'b10:   w_next = 1'b1;
               2'b11:   w_next = ~r_q;
               default: w_next = r_q;
            endcase
         end
         MODE_SR: begin
            case ({i_a, i_b})
               2'b01:   w_next = 1'b0;
               2'b10:   w_next = 1'b1;
               default: w_next = r_q;
            endcase
         end
         MODE_T:  w_next = i_a ? ~r_q : r_q;
         MODE_D:  w_next = i_a;
         default: w_next = r_q;
      endcase
   end

   // State, its complement and the change marker all register on the falling edge
   always_ff @(negedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_q       <= RST_BIT;
         r_qbar    <= ~RST_BIT;
         r_changed <= 1'b0;
      end else if (i_en) begin
         r_q       <= w_next;
         r_qbar    <= ~w_next;
         r_changed <= w_next ^ r_q;
      end else begin
         r_changed <= 1'b0;
      end
   end

   // S=R=1 in SR mode is the only illegal request; it only counts when updates are enabled
   assign o_illegal = i_en && (i_mode == MODE_SR) && i_a && i_b;

   assign o_q       = r_q;
   assign o_qbar    = r_qbar;
   assign o_changed = r_changed;

endmodule

// File: rtl/jk_ff_bank.sv
// rtl/jk_ff_bank.sv - WIDTH-bit bank of mode-selectable flip-flops with sticky SR error flag
module jk_ff_bank
   import jk_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic [1:0]       i_mode,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_clr_err,
   output logic [WIDTH-1:0] o_q,
   output logic [WIDTH-1:0] o_qbar,
   output logic [WIDTH-1:0] o_changed,
   output logic             o_sr_err
);

   mode_t            w_mode;
   logic [WIDTH-1:0] w_illegal;
   logic             w_any_illegal;
   logic             r_sr_err;

   assign w_mode = mode_t'(i_mode);

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      jk_ff_cell #(
         .RST_BIT (RST_VAL[gi])
      ) u_cell (
         .i_clk     (i_clk),
         .i_rst     (i_rst),
         .i_en      (i_en),
         .i_mode    (w_mode),
         .i_a       (i_a[gi]),
         .i_b       (i_b[gi]),
         .o_q       (o_q[gi]),
         .o_qbar    (o_qbar[gi]),
         .o_changed (o_changed[gi]),
         .o_illegal (w_illegal[gi])
      );
   end

   assign w_any_illegal = |w_illegal;

   // Sticky error: a new illegal request outranks a simultaneous clear
   always_ff @(negedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sr_err <= 1'b0;
      end else if (w_any_illegal) begin
         r_sr_err <= 1'b1;
      end else if (i_clr_err) begin
         r_sr_err <= 1'b0;
      end
   end

   assign o_sr_err = r_sr_err;

endmodule

// File: tb/tb_jk_ff_bank.sv
// tb/tb_jk_ff_bank.sv - directed and random scoreboard bench for jk_ff_bank
module tb_jk_ff_bank;

   logic       clk;
   logic       rst;
   logic       en;
   logic [1:0] mode;
   logic [7:0] a;
   logic [7:0] b;
   logic       clr_err;
   logic [7:0] q;
   logic [7:0] qbar;
   logic [7:0] changed;
   logic       sr_err;

   int passed = 0;
   int total  = 0;

   typedef struct {
      string      tag;
      logic [7:0] q;
      logic [7:0] chg;
      logic       err;
   } exp_t;

   exp_t sb[$];

   logic [7:0] m_q;
   logic       m_err;

   jk_ff_bank #(
      .WIDTH   (8),
      .RST_VAL (8'h00)
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_en      (en),
      .i_mode    (mode),
      .i_a       (a),
      .i_b       (b),
      .i_clr_err (clr_err),
      .o_q       (q),
      .o_qbar    (qbar),
      .o_changed (changed),
      .o_sr_err  (sr_err)
   );

   initial begin
      clk = 1'b1;
      forever #5 clk = ~clk;
   end

   task automatic cmp8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic cmp1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   task automatic check_out();
      exp_t e;
      e = sb.pop_front();
      cmp8({e.tag, ".q"}, q, e.q);
      cmp8({e.tag, ".qbar"}, qbar, ~e.q);
      cmp8({e.tag, ".changed"}, changed, e.chg);
      cmp1({e.tag, ".sr_err"}, sr_err, e.err);
   endtask

   // Independent bitwise formulation of the four bit functions
   function automatic logic [7:0] model_next(input logic [7:0] cq, input logic [1:0] m,
                                             input logic [7:0] ia, input logic [7:0] ib);
      case (m)
         2'b00:   return (ia & ~cq) | (~ib & cq);
         2'b01:   return (ia & ~ib) | (cq & ~(ib & ~ia));
         2'b10:   return cq ^ ia;
         default: return ia;
      endcase
   endfunction

   task automatic step(input logic ien, input logic [1:0] imode, input logic [7:0] ia,
                       input logic [7:0] ib, input logic iclr, input string tag);
      exp_t       e;
      logic [7:0] nq;
      en      = ien;
      mode    = imode;
      a       = ia;
      b       = ib;
      clr_err = iclr;
      nq = ien ? model_next(m_q, imode, ia, ib) : m_q;
      if (ien && imode == 2'b01 && |(ia & ib)) m_err = 1'b1;
      else if (iclr) m_err = 1'b0;
      e.tag = tag;
      e.q   = nq;
      e.chg = nq ^ m_q;
      e.err = m_err;
      sb.push_back(e);
      m_q = nq;
      @(negedge clk);
      #1;
      check_out();
   endtask

   task automatic expect_reset(input string tag);
      exp_t e;
      e.tag = tag;
      e.q   = 8'h00;
      e.chg = 8'h00;
      e.err = 1'b0;
      sb.push_back(e);
      check_out();
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; mode = 2'b11; a = 8'hFF; b = 8'h00; clr_err = 1'b0;
      m_q = 8'h00; m_err = 1'b0;
      #2;
      expect_reset("rst_init");
      @(negedge clk);
      #1;
      expect_reset("rst_edge_ignored");
      @(posedge clk);
      rst = 1'b0;

      step(1'b1, 2'b00, 8'hF0, 8'h0F, 1'b0, "jk_setclr");
      cmp8("jk_setclr_const", q, 8'hF0);
      step(1'b1, 2'b00, 8'hFF, 8'hFF, 1'b0, "jk_toggle");
      cmp8("jk_toggle_const", q, 8'h0F);
      cmp8("jk_toggle_chg_const", changed, 8'hFF);
      step(1'b1, 2'b00, 8'h00, 8'h00, 1'b0, "jk_hold");
      cmp8("jk_hold_chg_const", changed, 8'h00);
      step(1'b1, 2'b01, 8'h81, 8'h01, 1'b0, "sr_illegal");
      cmp8("sr_illegal_q_const", q, 8'h8F);
      cmp1("sr_illegal_err_const", sr_err, 1'b1);
      step(1'b1, 2'b00, 8'h00, 8'h00, 1'b0, "err_sticky");
      step(1'b1, 2'b01, 8'h00, 8'h00, 1'b1, "err_clear");
      cmp1("err_clear_const", sr_err, 1'b0);
      step(1'b1, 2'b10, 8'hAA, 8'h55, 1'b0, "t_mode");
      cmp8("t_mode_const", q, 8'h25);
      step(1'b1, 2'b11, 8'h3C, 8'hFF, 1'b0, "d_mode");
      cmp8("d_mode_const", q, 8'h3C);
      step(1'b0, 2'b11, 8'hFF, 8'hFF, 1'b0, "en_off");
      cmp8("en_off_const", q, 8'h3C);

      #3;
      en = 1'b1; mode = 2'b11; a = 8'hFF; b = 8'h00;
      rst = 1'b1;
      #1;
      expect_reset("async_rst");
      @(negedge clk);
      #1;
      expect_reset("rst_mid_edge_ignored");
      @(posedge clk);
      rst = 1'b0;
      m_q = 8'h00;
      m_err = 1'b0;

      step(1'b1, 2'b01, 8'h01, 8'h01, 1'b1, "set_wins");
      cmp1("set_wins_const", sr_err, 1'b1);
      step(1'b1, 2'b00, 8'h00, 8'h00, 1'b1, "clr_only");

      for (int i = 0; i < 24; i++) begin
         step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
              8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
